// File: rtl/recip_mean_ctrl_pkg.sv
// Shared definitions for the reciprocal-mean sequencer:
// state encoding, reciprocal format and frame limits.
package recip_mean_ctrl_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_LOOKUP = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam int RECIP_FRAC_BITS = 8;
  localparam int MAX_FRAME       = 16;
  localparam int CNT_W = $clog2(MAX_FRAME) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ACCUM  = S_ACCUM,
    ST_LOOKUP = S_LOOKUP,
    ST_OUT    = S_OUT
  } state_t;

endpackage

// File: rtl/recip_mean_ctrl_lut.sv
// Reciprocal ROM: addr = N-1, data = floor(256/N) in Q0.8,
// entry 0 clipped to 0xFF. Ports: addr_i (4b), data_o (16b, upper byte 0).
module recip_mean_ctrl_lut (
  input  logic [3:0]  addr_i,
  output logic [15:0] data_o
);

  always_comb begin
    data_o = 16'h0000;
    unique case (addr_i)
      4'd0:  data_o = 16'h00FF;
      4'd1:  data_o = 16'h0080;
      4'd2:  data_o = 16'h0055;
      4'd3:  data_o = 16'h0040;
      4'd4:  data_o = 16'h0033;
      4'd5:  data_o = 16'h002A;
      4'd6:  data_o = 16'h0024;
      4'd7:  data_o = 16'h0020;
      4'd8:  data_o = 16'h001C;
      4'd9:  data_o = 16'h0019;
      4'd10: data_o = 16'h0017;
      4'd11: data_o = 16'h0015;
      4'd12: data_o = 16'h0013;
      4'd13: data_o = 16'h0012;
      4'd14: data_o = 16'h0011;
      4'd15: data_o = 16'h0010;
      default: data_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/recip_mean_ctrl.sv
// Frame-mean sequencer: accumulates 1..16 samples, multiplies by 1/N
// from a reciprocal ROM and presents mean+count on a valid/ready port.
// Ports: clk, rst_n, cfg_n (N-1), in_* sample stream, flush,
// out_* result stream, busy.
module recip_mean_ctrl
  import recip_mean_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cfg_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mean,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int PROD_W = SUM_W + 16;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         target_q, target_d;
  logic [DATA_W-1:0]  mean_q, mean_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               beat;
  logic               last;
  logic [3:0]         lut_addr;
  logic [15:0]        lut_data;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  quo;
  logic               sat;

  // Address only from registered count so the ROM
  // never sees the input path.
  assign lut_addr = 4'(cnt_q - CNT_W'(1));

  recip_mean_ctrl_lut u_lut (
    .addr_i (lut_addr),
    .data_o (lut_data)
  );

  assign prod = PROD_W'(sum_q) * PROD_W'(lut_data);
  assign quo  = prod >> RECIP_FRAC_BITS;
  assign sat  = |quo[PROD_W-1:DATA_W];

  assign beat = in_valid & in_ready;
  // cnt_q == target means this beat completes the frame
  assign last = (cnt_q == CNT_W'(target_q));

  assign in_ready  = (state_q == ST_IDLE) |
                     (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_mean  = mean_q;
  assign out_count = count_q;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    mean_d   = mean_q;
    count_d  = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          target_d = cfg_n;
          sum_d    = SUM_W'(in_data);
          cnt_d    = CNT_W'(1);
          if ((cfg_n == 4'd0) || flush)
            state_d = ST_LOOKUP;
          else
            state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          sum_d = sum_q + SUM_W'(in_data);
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush || (beat && last))
          state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        // ROM entry 0 is 0xFF, so N=1 takes the sum directly
        if (cnt_q == CNT_W'(1))
          mean_d = sum_q[DATA_W-1:0];
        else if (sat)
          mean_d = '1;
        else
          mean_d = quo[DATA_W-1:0];
        count_d = cnt_q;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      mean_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mean_q   <= mean_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_recip_mean_ctrl.sv
// Self-checking bench for recip_mean_ctrl: frame table with
// expected means, scoreboard on the output port, corner sequences.
module tb_recip_mean_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cfg_n = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_mean;
  logic [4:0] out_count;
  logic       busy;

  recip_mean_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_n     (cfg_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cfg;
    int         nb;
    logic [7:0] base;
    logic [7:0] step;
    int         fmode;
    logic [7:0] mean;
    logic [4:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [7:0] m;
    logic [4:0] c;
  } exp_t;

  vec_t tv[12];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name,
                       input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_mean", int'(out_mean), int'(e.m));
        check("out_count", int'(out_count), int'(e.c));
      end
    end
  end

  task automatic wait_ready;
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 0, 1);
  endtask

  // Drives one frame; leaves the DUT in its LOOKUP cycle.
  task automatic send_frame(input vec_t v, input bit push);
    exp_t e;
    wait_ready();
    if (push) begin
      e.m = v.mean;
      e.c = v.cnt;
      sb.push_back(e);
    end
    for (int i = 0; i < v.nb; i++) begin
      logic [7:0] d;
      d = v.base + v.step * 8'(i);
      in_valid = 1'b1;
      in_data  = d;
      cfg_n    = (i == 0) ? v.cfg : 4'($urandom);
      flush    = (v.fmode == 1) && (i == v.nb - 1);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (v.fmode == 2) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
  endtask

  initial begin
    vec_t bp;
    vec_t rv;

    tv[0]  = '{4'd3,  4,  8'd10,  8'd10,  0, 8'd25,  5'd4};
    tv[1]  = '{4'd0,  1,  8'd200, 8'd0,   0, 8'd200, 5'd1};
    tv[2]  = '{4'd2,  3,  8'd255, 8'd0,   0, 8'd254, 5'd3};
    tv[3]  = '{4'd15, 5,  8'd50,  8'd0,   1, 8'd49,  5'd5};
    tv[4]  = '{4'd7,  8,  8'd1,   8'd1,   0, 8'd4,   5'd8};
    tv[5]  = '{4'd9,  10, 8'd100, 8'd0,   0, 8'd97,  5'd10};
    tv[6]  = '{4'd5,  6,  8'd0,   8'd50,  0, 8'd123, 5'd6};
    tv[7]  = '{4'd1,  2,  8'd255, 8'd255, 0, 8'd254, 5'd2};
    tv[8]  = '{4'd15, 3,  8'd30,  8'd0,   2, 8'd29,  5'd3};
    tv[9]  = '{4'd0,  1,  8'd0,   8'd0,   1, 8'd0,   5'd1};
    tv[10] = '{4'd15, 1,  8'd77,  8'd0,   1, 8'd77,  5'd1};
    tv[11] = '{4'd11, 12, 8'd200, 8'd0,   0, 8'd196, 5'd12};

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_mean", int'(out_mean), 0);
    check("rst_out_count", int'(out_count), 0);
    #10;
    rst_n = 1'b1;
    tick();

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush_busy", int'(busy), 0);

    for (int k = 0; k < 12; k++) begin
      send_frame(tv[k], 1'b1);
      @(negedge clk);
      check("lookup_valid", int'(out_valid), 0);
      check("lookup_in_ready", int'(in_ready), 0);
      tick();
      @(negedge clk);
      check("t2_valid", int'(out_valid), 1);
      tick();
    end

    bp = '{4'd15, 16, 8'd255, 8'd0, 0, 8'd255, 5'd16};
    out_ready = 1'b0;
    send_frame(bp, 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_mean", int'(out_mean), 255);
      check("bp_count", int'(out_count), 16);
    end
    tick();
    out_ready = 1'b1;
    tick();
    check("bp_idle_busy", int'(busy), 0);
    check("bp_idle_valid", int'(out_valid), 0);
    check("bp_idle_ready", int'(in_ready), 1);
    check("bp_sb_empty", sb.size(), 0);

    rv = '{4'd7, 3, 8'd99, 8'd0, 0, 8'd0, 5'd0};
    send_frame(rv, 1'b0);
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", int'(busy), 0);
    check("mr_valid", int'(out_valid), 0);
    check("mr_mean", int'(out_mean), 0);
    check("mr_count", int'(out_count), 0);
    check("mr_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    rv = '{4'd1, 2, 8'd7, 8'd2, 0, 8'd8, 5'd2};
    send_frame(rv, 1'b1);

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    check("sb_drained", sb.size(), 0);
    tick();
    check("end_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
